// File: rtl/instruction_encoder_loader.sv
// Packs MIPS instruction fields into 32-bit words by format and writes them to
// sequential instruction-memory addresses during a start/finish load session.
module instruction_encoder_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int BASE   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [5:0]        Control,
    input  logic [4:0]        read1,
    input  logic [4:0]        read2,
    input  logic [4:0]        write,
    input  logic [4:0]        shamt,
    input  logic [5:0]        alu_control,
    input  logic [15:0]       immediate_data,
    input  logic [25:0]       jumpAdd,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0]   FULL   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       packed_word;
    logic              accept;
    logic              legal;
    logic              illegal;
    logic              overflow;

    assign in_ready = (state == LOAD) && (count < FULL);
    assign busy     = (state == LOAD);
    assign done     = (state == DONE);

    // start has priority over any bundle presented on the same edge
    assign accept   = in_valid && in_ready && !start;
    assign legal    = accept && (fmt != 2'd3);
    assign illegal  = accept && (fmt == 2'd3);
    assign overflow = in_valid && (state == DONE) && (count == FULL);

    always_comb begin
        packed_word = '0;
        case (fmt)
            2'd0:    packed_word = {Control, read1, read2, write, shamt, alu_control};
            2'd1:    packed_word = {Control, read1, read2, immediate_data};
            2'd2:    packed_word = {Control, jumpAdd};
            default: packed_word = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = LOAD;
            LOAD: begin
                if (start)
                    state_next = LOAD;
                else if (finish || (legal && (count == FULL - 1'b1)))
                    state_next = DONE;
            end
            DONE: if (start) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= BASE_A;
            count     <= '0;
            err       <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state  <= state_next;
            mem_we <= legal;
            if (legal) begin
                mem_addr  <= ptr;
                mem_wdata <= packed_word;
            end
            if (start) begin
                ptr   <= BASE_A;
                count <= '0;
                err   <= 1'b0;
            end else begin
                if (legal) begin
                    ptr   <= ptr + ADDR_W'(1);
                    count <= count + (ADDR_W+1)'(1);
                end
                if (illegal || overflow)
                    err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Directed and randomized checks of instruction_encoder_loader against a
// cycle-level behavioural model of the load session.
module tb_instruction_encoder_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, finish = 1'b0, in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  fmt = '0;
    logic [5:0]  Control = '0;
    logic [4:0]  read1 = '0, read2 = '0, write = '0, shamt = '0;
    logic [5:0]  alu_control = '0;
    logic [15:0] immediate_data = '0;
    logic [25:0] jumpAdd = '0;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [5:0]  count;
    logic        busy, done, err;

    int total = 0;
    int bad   = 0;

    // behavioural model
    bit          m_load, m_done, m_err, m_we;
    int          m_ptr, m_cnt, m_addr;
    int unsigned m_wdata;

    instruction_encoder_loader #(.DEPTH(32), .ADDR_W(5), .BASE(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt),
        .Control(Control), .read1(read1), .read2(read2), .write(write),
        .shamt(shamt), .alu_control(alu_control),
        .immediate_data(immediate_data), .jumpAdd(jumpAdd),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned pack_word();
        int unsigned op = 32'(Control) * 32'h0400_0000;
        case (fmt)
            2'd0: return op + 32'(read1) * 32'h20_0000 + 32'(read2) * 32'h1_0000
                     + 32'(write) * 32'h800 + 32'(shamt) * 32'h40 + 32'(alu_control);
            2'd1: return op + 32'(read1) * 32'h20_0000 + 32'(read2) * 32'h1_0000
                     + 32'(immediate_data);
            default: return op + 32'(jumpAdd);
        endcase
    endfunction

    task automatic model_reset();
        m_load = 0; m_done = 0; m_err = 0; m_we = 0;
        m_ptr = 0; m_cnt = 0; m_addr = 0; m_wdata = 0;
    endtask

    task automatic cycle();
        bit rdy;
        rdy = m_load && (m_cnt < 32);
        check("in_ready", in_ready, rdy);
        @(posedge clk);
        m_we = 0;
        if (start) begin
            m_load = 1; m_done = 0; m_ptr = 0; m_cnt = 0; m_err = 0;
        end else begin
            if (rdy && in_valid) begin
                if (fmt == 2'd3) m_err = 1;
                else begin
                    m_we = 1; m_addr = m_ptr; m_wdata = pack_word();
                    m_ptr = (m_ptr + 1) % 32;
                    m_cnt++;
                    if (m_cnt == 32) begin m_load = 0; m_done = 1; end
                end
            end else if (in_valid && m_done && m_cnt == 32) begin
                m_err = 1;
            end
            if (finish && m_load) begin m_load = 0; m_done = 1; end
        end
        #1;
        check("mem_we", mem_we, m_we);
        if (m_we) begin
            check("mem_addr", mem_addr, m_addr);
            check("mem_wdata", mem_wdata, m_wdata);
        end
        check("count", count, m_cnt);
        check("err", err, m_err);
        check("busy", busy, m_load);
        check("done", done, m_done);
    endtask

    task automatic idle_inputs();
        start = 0; finish = 0; in_valid = 0;
    endtask

    task automatic set_bundle(input logic [1:0] f, input logic [5:0] op, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                              input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] ja);
        in_valid = 1; fmt = f; Control = op; read1 = rs; read2 = rt; write = rd;
        shamt = sh; alu_control = fn; immediate_data = imm; jumpAdd = ja;
    endtask

    task automatic rand_bundle();
        int r;
        r = $urandom_range(0, 9);
        set_bundle((r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3,
                   6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                   6'($urandom), 16'($urandom), 26'($urandom));
        in_valid = ($urandom_range(0, 9) < 7);
    endtask

    task automatic do_start();
        idle_inputs(); start = 1; cycle(); start = 0;
    endtask

    initial begin
        model_reset();
        #12;
        check("reset_we", mem_we, 1'b0);
        check("reset_count", count, 6'd0);
        check("reset_state", {busy, done, err}, 3'b000);
        @(negedge clk); rst_n = 1;
        cycle();

        // 1: single R-format word
        do_start();
        set_bundle(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
        cycle();
        check("t1_wdata", mem_wdata, 32'h0022_1820);
        check("t1_addr", mem_addr, 5'd0);

        // 2: I then J back-to-back
        do_start();
        set_bundle(2'd1, 6'h23, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'h0);
        cycle();
        check("t2_i", mem_wdata, 32'h8C08_0004);
        set_bundle(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h10);
        cycle();
        check("t2_j", {27'(mem_addr), mem_wdata}, {27'd1, 32'h0800_0010});
        idle_inputs(); cycle();

        // 3: illegal format sets err; next start clears it
        set_bundle(2'd3, 6'h3F, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1, 26'h1);
        cycle();
        check("t3_err", err, 1'b1);
        do_start();
        check("t3_clear", err, 1'b0);

        // 4: fill to DEPTH, then overflow attempt
        for (int i = 0; i < 32; i++) begin
            set_bundle(2'd2, 6'($urandom), 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'(i));
            cycle();
        end
        check("t4_full", {done, in_ready, count}, {1'b1, 1'b0, 6'd32});
        set_bundle(2'd0, 6'd1, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'd0, 26'd0);
        cycle();
        check("t4_over", {err, mem_we}, 2'b10);

        // 5: finish coincident with the third accept
        do_start();
        for (int i = 0; i < 3; i++) begin
            set_bundle(2'd1, 6'h08, 5'(i), 5'(i + 1), 5'd0, 5'd0, 6'd0, 16'(i * 7), 26'd0);
            finish = (i == 2);
            cycle();
        end
        finish = 0; idle_inputs(); cycle();
        check("t5_end", {done, count}, {1'b1, 6'd3});

        // 6: asynchronous reset while a write is on the bus
        do_start();
        set_bundle(2'd0, 6'd0, 5'd4, 5'd5, 5'd6, 5'd1, 6'h22, 16'd0, 26'd0);
        cycle();
        idle_inputs();
        #2 rst_n = 0;
        #1;
        model_reset();
        check("t6_we", mem_we, 1'b0);
        check("t6_state", {busy, done, err, count}, 9'd0);
        @(negedge clk); rst_n = 1;
        cycle();

        // randomized sessions
        for (int n = 0; n < 3000; n++) begin
            rand_bundle();
            start  = ($urandom_range(0, 99) < 3);
            finish = ($urandom_range(0, 99) < 2);
            cycle();
        end
        idle_inputs(); cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
